fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the control unit in the pipelined core. It owns the PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, and holds returned instructions in a 2-entry in-order buffer. It presents the head instruction, its PC and the pre-sliced decode fields (opcode, funct3, funct7 bit) to decode under a valid/ready handshake. Control-flow redirects squash all buffered and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 43 ++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// ============================================================================
// imem_if / dec_if : fetch-side bus bundles (memory handshake, decode handshake)
// Rev 1.0
// ============================================================================
`default_nettype none

interface imem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

interface dec_if;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic        dec_funct7;

    modport master (
        output dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct3, dec_funct7,
        input  dec_ready
    );
    modport slave (
        input  dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct3, dec_funct7,
        output dec_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC owner, credit-limited imem requester, 2-entry decode buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        redirect,
    input  wire logic [31:0] redirect_pc,
    imem_if.master           imem,
    dec_if.master            dec
);

    logic        started_q, started_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  discard_q, discard_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic [31:0] buf_pc_q    [2];
    logic [31:0] buf_pc_d    [2];
    logic [31:0] ifq_pc_q    [2];
    logic [31:0] ifq_pc_d    [2];

    logic        w_valid;
    logic        w_pop;
    logic        w_resp;
    logic        w_req;
    logic        w_grant;
    logic        w_drop;
    logic        w_push;
    logic [2:0]  w_credit;
    logic        w_buf_wr_idx;
    logic        w_ifq_wr_idx;

    assign w_valid  = (count_q != 2'd0);
    assign w_pop    = w_valid & dec.dec_ready;
    // A response with nothing outstanding belongs to a pre-reset request.
    assign w_resp   = imem.imem_rvalid & (outstanding_q != 2'd0);
    assign w_credit = {1'b0, outstanding_q} + {1'b0, count_q} - {2'b00, w_pop};
    assign w_req    = started_q & ~redirect & (w_credit < 3'd2);
    assign w_grant  = w_req & imem.imem_gnt;
    assign w_drop   = w_resp & ((discard_q != 2'd0) | redirect);
    assign w_push   = w_resp & ~w_drop;

    // Tail slot after this cycle's pop; the credit rule keeps it within 0..1.
    assign w_buf_wr_idx = (count_q == 2'd2) | ((count_q == 2'd1) & ~w_pop);
    assign w_ifq_wr_idx = (outstanding_q == 2'd2) | ((outstanding_q == 2'd1) & ~w_resp);

    always_comb begin
        started_d     = 1'b1;
        pc_d          = pc_q;
        outstanding_d = outstanding_q + {1'b0, w_grant} - {1'b0, w_resp};
        discard_d     = discard_q;
        count_d       = count_q - {1'b0, w_pop} + {1'b0, w_push};
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        ifq_pc_d      = ifq_pc_q;

        if (w_pop) begin
            buf_instr_d[0] = buf_instr_q[1];
            buf_pc_d[0]    = buf_pc_q[1];
        end
        if (w_push) begin
            buf_instr_d[w_buf_wr_idx] = imem.imem_rdata;
            buf_pc_d[w_buf_wr_idx]    = ifq_pc_q[0];
        end

        if (w_resp) begin
            ifq_pc_d[0] = ifq_pc_q[1];
        end
        if (w_grant) begin
            ifq_pc_d[w_ifq_wr_idx] = pc_q;
        end

        if (w_resp && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
        end

        if (redirect) begin
            pc_d      = redirect_pc;
            count_d   = 2'd0;
            // No grant is possible here, so only the consumed response leaves.
            discard_d = outstanding_q - {1'b0, w_resp};
        end else if (w_grant) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q     <= 1'b0;
            pc_q          <= RESET_PC;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
            count_q       <= 2'd0;
            buf_instr_q   <= '{default: '0};
            buf_pc_q      <= '{default: '0};
            ifq_pc_q      <= '{default: '0};
        end else begin
            started_q     <= started_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            ifq_pc_q      <= ifq_pc_d;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = pc_q;

    assign dec.dec_valid  = w_valid;
    assign dec.dec_instr  = buf_instr_q[0];
    assign dec.dec_pc     = buf_pc_q[0];
    assign dec.dec_opcode = buf_instr_q[0][6:0];
    assign dec.dec_funct3 = buf_instr_q[0][14:12];
    assign dec.dec_funct7 = buf_instr_q[0][30];

endmodule

`default_nettype wire
